sync_fifo_ctrl: RTL and testbench

- Single-clock FIFO pointer and status controller; the generalised successor to the FIFO pointer/flag logic.
- Drives write/read addresses for an external dual-port RAM.
- Supports arbitrary (non-power-of-two) depth, fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and synchronous flush.
- Sits between producer/consumer handshakes and the FIFO storage array.

---
 rtl/sync_fifo_ctrl.sv | 92 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Pointer, fill-count and status controller for a single-clock FIFO built around
// an external dual-port RAM; depth need not be a power of two.
module sync_fifo_ctrl #(
   parameter int ADDRWIDTH = 8,
   parameter int DEPTH     = 256,
   parameter int AFULL     = 252,
   parameter int AEMPTY    = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic                 flush,
   input  logic                 clear_err,
   output logic                 wr_ack,
   output logic                 rd_ack,
   output logic [ADDRWIDTH-1:0] waddr,
   output logic [ADDRWIDTH-1:0] raddr,
   output logic [ADDRWIDTH:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 almostfull,
   output logic                 almostempty,
   output logic                 overflow,
   output logic                 underflow
);

   localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);
   localparam logic [ADDRWIDTH:0]   DEPTH_C   = (ADDRWIDTH + 1)'(DEPTH);
   localparam logic [ADDRWIDTH:0]   AFULL_C   = (ADDRWIDTH + 1)'(AFULL);
   localparam logic [ADDRWIDTH:0]   AEMPTY_C  = (ADDRWIDTH + 1)'(AEMPTY);

   logic [ADDRWIDTH-1:0] wptr;
   logic [ADDRWIDTH-1:0] rptr;
   logic [ADDRWIDTH:0]   cnt;
   logic                 ovf_q;
   logic                 udf_q;
   logic                 ovf_set;
   logic                 udf_set;

   // Status decodes from the registered count only, so requests never reach a flag.
   assign full        = (cnt == DEPTH_C);
   assign empty       = (cnt == '0);
   assign almostfull  = (cnt >= AFULL_C);
   assign almostempty = (cnt <= AEMPTY_C);

   // Handshake: wr_en/rd_en are requests that may be held any number of cycles;
   // a request is consumed exactly on a cycle where its ack is high, and the ack
   // doubles as the RAM strobe for the address presented in that same cycle.
   assign wr_ack  = reset & wr_en & ~full  & ~flush;
   assign rd_ack  = reset & rd_en & ~empty & ~flush;
   assign ovf_set = wr_en & full  & ~flush;
   assign udf_set = rd_en & empty & ~flush;

   assign waddr     = wptr;
   assign raddr     = rptr;
   assign count     = cnt;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr_ack) wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
         if (rd_ack) rptr <= (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
         case ({wr_ack, rd_ack})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // A new error in the same cycle as clear_err keeps the flag set.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_set | (ovf_q & ~clear_err);
         udf_q <= udf_set | (udf_q & ~clear_err);
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised and directed bench for sync_fifo_ctrl (DEPTH=6) against a queue-based
// model of FIFO occupancy and slot addresses.
module tb_sync_fifo_ctrl;

   localparam int AW = 3;
   localparam int D  = 6;
   localparam int AF = 5;
   localparam int AE = 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          wr_en, rd_en, flush, clear_err;
   logic          wr_ack, rd_ack;
   logic [AW-1:0] waddr, raddr;
   logic [AW:0]   count;
   logic          full, empty, almostfull, almostempty, overflow, underflow;

   int errors = 0;
   int checks = 0;

   // Reference model: the queue holds the RAM slot of every stored entry in order.
   logic [AW-1:0] exp_q[$];
   int            m_wp, m_rp;
   logic          m_ovf, m_udf;

   sync_fifo_ctrl #(.ADDRWIDTH(AW), .DEPTH(D), .AFULL(AF), .AEMPTY(AE)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .clear_err(clear_err), .wr_ack(wr_ack), .rd_ack(rd_ack), .waddr(waddr),
      .raddr(raddr), .count(count), .full(full), .empty(empty),
      .almostfull(almostfull), .almostempty(almostempty), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clock = ~clock;

   // One clock of stimulus; outputs are compared with the model at the negedge,
   // and the model advances after the posedge.
   task automatic cycle(input logic w, input logic r, input logic f, input logic c);
      int   n;
      logic e_full, e_empty, e_wack, e_rack;
      logic [7:0] e_flags;
      wr_en = w; rd_en = r; flush = f; clear_err = c;
      @(negedge clock);
      n       = exp_q.size();
      e_full  = (n == D);
      e_empty = (n == 0);
      e_wack  = w && !e_full && !f;
      e_rack  = r && !e_empty && !f;
      e_flags = {e_wack, e_rack, e_full, e_empty, (n >= AF), (n <= AE), m_ovf, m_udf};
      checks += 4;
      if ({wr_ack, rd_ack, full, empty, almostfull, almostempty, overflow, underflow} !== e_flags) begin
         errors++;
         $display("FAIL sb_flags got %b exp %b (ack_w,ack_r,full,empty,af,ae,ovf,udf)",
                  {wr_ack, rd_ack, full, empty, almostfull, almostempty, overflow, underflow}, e_flags);
      end
      if (count !== (AW + 1)'(n)) begin
         errors++; $display("FAIL sb_count got %0d exp %0d", count, n);
      end
      if (waddr !== AW'(m_wp)) begin
         errors++; $display("FAIL sb_waddr got %0d exp %0d", waddr, m_wp);
      end
      if (raddr !== AW'(m_rp)) begin
         errors++; $display("FAIL sb_raddr got %0d exp %0d", raddr, m_rp);
      end
      if (e_rack) begin
         checks++;
         if (raddr !== exp_q[0]) begin
            errors++; $display("FAIL sb_read_slot got %0d exp %0d", raddr, exp_q[0]);
         end
      end
      @(posedge clock); #1;
      if (f) begin
         exp_q.delete(); m_wp = 0; m_rp = 0;
      end else begin
         if (e_rack) begin
            void'(exp_q.pop_front());
            m_rp = (m_rp + 1) % D;
         end
         if (e_wack) begin
            exp_q.push_back(AW'(m_wp));
            m_wp = (m_wp + 1) % D;
         end
      end
      m_ovf = (w && e_full && !f) || (m_ovf && !c);
      m_udf = (r && e_empty && !f) || (m_udf && !c);
   endtask

   task automatic apply_reset(input int cycles, input logic w, input logic r);
      reset = 1'b0; wr_en = w; rd_en = r; flush = 1'b0; clear_err = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         checks++;
         if ({wr_ack, rd_ack} !== 2'b00) begin
            errors++; $display("FAIL reset_acks got %b exp 00", {wr_ack, rd_ack});
         end
         @(posedge clock); #1;
      end
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
      exp_q.delete(); m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_udf = 1'b0;
      checks += 3;
      if (count !== 4'd0) begin
         errors++; $display("FAIL reset_count got %0d exp 0", count);
      end
      if ({empty, almostempty, full, almostfull, overflow, underflow} !== 6'b110000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 110000",
                  {empty, almostempty, full, almostfull, overflow, underflow});
      end
      if ({waddr, raddr} !== 6'd0) begin
         errors++; $display("FAIL reset_addr got w=%0d r=%0d exp 0/0", waddr, raddr);
      end
   endtask

   task automatic test_reset();
      apply_reset(2, 1'b1, 1'b1);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < D; i++) begin
         checks += 2;
         if (waddr !== AW'(i)) begin
            errors++; $display("FAIL wrap_waddr got %0d exp %0d", waddr, i);
         end
         if (almostfull !== (i >= AF)) begin
            errors++; $display("FAIL wrap_afull at count %0d got %b", i, almostfull);
         end
         cycle(1, 0, 0, 0);
      end
      checks += 3;
      if (full !== 1'b1) begin errors++; $display("FAIL wrap_full got %b exp 1", full); end
      if (count !== 4'd6) begin errors++; $display("FAIL wrap_count got %0d exp 6", count); end
      if (waddr !== 3'd0) begin errors++; $display("FAIL wrap_wptr got %0d exp 0", waddr); end
      for (int i = 0; i < D; i++) begin
         checks++;
         if (raddr !== AW'(i)) begin
            errors++; $display("FAIL wrap_raddr got %0d exp %0d", raddr, i);
         end
         cycle(0, 1, 0, 0);
      end
      checks += 2;
      if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
      if (raddr !== 3'd0) begin errors++; $display("FAIL wrap_rptr got %0d exp 0", raddr); end
   endtask

   task automatic test_full_boundary();
      for (int i = 0; i < D; i++) cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      checks += 2;
      if (count !== 4'd5) begin errors++; $display("FAIL full_rw_count got %0d exp 5", count); end
      if (overflow !== 1'b1) begin errors++; $display("FAIL full_rw_ovf got %b exp 1", overflow); end
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 1);
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
      cycle(0, 0, 0, 1);
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
   endtask

   task automatic test_empty_boundary();
      int wp0, rp0;
      while (exp_q.size() > 0) cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      checks += 2;
      if (count !== 4'd1) begin errors++; $display("FAIL empty_rw_count got %0d exp 1", count); end
      if (underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_udf got %b exp 1", underflow); end
      cycle(0, 0, 0, 1);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      wp0 = m_wp; rp0 = m_rp;
      for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
      checks += 3;
      if (count !== 4'd3) begin errors++; $display("FAIL steady_count got %0d exp 3", count); end
      if (waddr !== AW'((wp0 + 10) % D)) begin
         errors++; $display("FAIL steady_waddr got %0d exp %0d", waddr, (wp0 + 10) % D);
      end
      if (raddr !== AW'((rp0 + 10) % D)) begin
         errors++; $display("FAIL steady_raddr got %0d exp %0d", raddr, (rp0 + 10) % D);
      end
   endtask

   task automatic test_flush();
      while (exp_q.size() < D) cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      checks += 2;
      if (count !== 4'd4) begin errors++; $display("FAIL flush_pre_count got %0d exp 4", count); end
      if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got %b exp 1", overflow); end
      cycle(1, 0, 1, 0);
      checks += 3;
      if (count !== 4'd0 || empty !== 1'b1) begin
         errors++; $display("FAIL flush_count got %0d empty %b exp 0/1", count, empty);
      end
      if ({waddr, raddr} !== 6'd0) begin
         errors++; $display("FAIL flush_ptrs got w=%0d r=%0d exp 0/0", waddr, raddr);
      end
      if (overflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf got %b exp 1", overflow); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      checks++;
      if ({count, waddr, raddr} !== {4'd3, 3'd5, 3'd2}) begin
         errors++; $display("FAIL midrst_pre got c=%0d w=%0d r=%0d exp 3/5/2", count, waddr, raddr);
      end
      apply_reset(1, 1'b1, 1'b0);
      checks++;
      if (waddr !== 3'd0) begin errors++; $display("FAIL midrst_waddr got %0d exp 0", waddr); end
      cycle(1, 0, 0, 0);
      checks++;
      if (count !== 4'd1) begin errors++; $display("FAIL midrst_write got %0d exp 1", count); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0));
   endtask

   initial begin
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clear_err = 1'b0;
      m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_udf = 1'b0;
      @(posedge clock); #1;
      test_reset();
      test_wrap();
      test_full_boundary();
      test_empty_boundary();
      test_flush();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
